// File: rtl/vend_input_conditioner.sv
// Coin/select front-end: two-flop sync, debounce, press-edge detect, and a one-output-per-cycle
// arbiter that serialises coin and select pulses and diverts coins to coin_reject at full credit.
//   state    | meaning
//   IDLE     | waiting for press events; coin wins a same-cycle tie
//   SEL_PEND | coin issued last cycle, deferred select issues now
module vend_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MAX_CREDIT      = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_raw,
   input  logic       sel_raw,
   input  logic [2:0] credit,
   output logic       m,
   output logic       a,
   output logic       coin_reject
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic IDLE     = 1'b0;
   localparam logic SEL_PEND = 1'b1;

   // Channel index 0 is the coin slot, index 1 the select button.
   logic [1:0]    meta_q, meta_d;
   logic [1:0]    sync_q, sync_d;
   logic [1:0]    db_q, db_d;
   logic [1:0]    db_dly_q, db_dly_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   logic          state_q, state_d;
   logic          coin_pend_q, coin_pend_d;
   logic          m_q, m_d;
   logic          a_q, a_d;
   logic          rej_q, rej_d;

   logic [1:0]    press_ev;
   logic          coin_ev;
   logic          sel_ev;
   logic          coin_req;
   logic          credit_full;

   assign press_ev    = db_q & ~db_dly_q;
   assign coin_ev     = press_ev[0];
   assign sel_ev      = press_ev[1];
   assign coin_req    = coin_ev | coin_pend_q;
   assign credit_full = ({29'd0, credit} >= 32'(MAX_CREDIT));

   always_comb begin
      meta_d   = {sel_raw, coin_raw};
      sync_d   = meta_q;
      db_dly_d = db_q;
      db_d     = db_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            db_d[i]  = sync_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      coin_pend_d = coin_pend_q;
      m_d         = 1'b0;
      a_d         = 1'b0;
      rej_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (coin_req) begin
               if (credit_full) rej_d = 1'b1;
               else             m_d   = 1'b1;
               coin_pend_d = 1'b0;
               if (sel_ev) state_d = SEL_PEND;
            end else if (sel_ev) begin
               a_d = 1'b1;
            end
         end
         SEL_PEND: begin
            a_d     = 1'b1;
            state_d = IDLE;
            // Unreachable with legal debounce spacing, but a coin here must not be lost.
            if (coin_ev) coin_pend_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q      <= '0;
         sync_q      <= '0;
         db_q        <= '0;
         db_dly_q    <= '0;
         cnt_q       <= '{default: '0};
         state_q     <= IDLE;
         coin_pend_q <= 1'b0;
         m_q         <= 1'b0;
         a_q         <= 1'b0;
         rej_q       <= 1'b0;
      end else begin
         meta_q      <= meta_d;
         sync_q      <= sync_d;
         db_q        <= db_d;
         db_dly_q    <= db_dly_d;
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         coin_pend_q <= coin_pend_d;
         m_q         <= m_d;
         a_q         <= a_d;
         rej_q       <= rej_d;
      end
   end

   assign m           = m_q;
   assign a           = a_q;
   assign coin_reject = rej_q;

endmodule

// File: doc/vend_input_conditioner.md
Name: vend_input_conditioner

Overview:
- Upstream front-end for the vending-machine credit FSM.
- Takes the raw asynchronous coin-slot and select-button contacts, synchronises and debounces them, and converts each press into a single-cycle pulse on m (coin) or a (select).
- m and a are never asserted together; simultaneous presses are serialised.
- Coins offered while credit is at maximum are diverted to a coin_reject pulse so the coin can be returned, instead of being silently ignored.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive identical synchronised samples required to accept a level change. Legal range is 2 or more.
- MAX_CREDIT, default 5: credit value at or above which a coin is rejected.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the clk rising edge; 0 = reset.
- coin_raw  input  1  raw coin-slot contact, asynchronous, may bounce. 1 = coin present.
- sel_raw  input  1  raw select button, asynchronous, may bounce. 1 = pressed.
- credit  input  3  current credit from the downstream FSM (its c output), unsigned.
- m  output  1  coin-accepted pulse, one cycle, registered.
- a  output  1  select pulse, one cycle, registered.
- coin_reject  output  1  coin-returned pulse, one cycle, registered.

Behaviour:
- Reset (reset=0 at a clk edge) clears the following, and takes effect that edge:
  - all synchroniser flops, debounced levels and their delayed copies;
  - debounce counters;
  - arbiter state (to IDLE);
  - m, a and coin_reject (all to 0).
- Reset is not applied asynchronously.
- Synchroniser: two flops per raw input, giving coin_s and sel_s.
- Debounce, per channel, with a stable level db and a counter cnt of width clog2(DEBOUNCE_CYCLES)+1:
  - If sync == db: cnt <= 0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: db <= sync and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Net effect: db flips only after DEBOUNCE_CYCLES consecutive differing samples. Any agreeing sample restarts the count.
- Press event: db rising, i.e. db & ~db_d, where db_d is db delayed one cycle. Falling edges generate nothing. A held button gives exactly one event.
- Latency: a raw input that goes high and stays high yields its output pulse in clock cycle DEBOUNCE_CYCLES+3, counting the first edge that samples it high as cycle 1. The pulse width is exactly 1 cycle.
- Arbiter FSM, states IDLE and SEL_PEND; outputs are registered and default to 0 every cycle:
  - IDLE, coin event only: if credit >= MAX_CREDIT, coin_reject <= 1; else m <= 1. Stay IDLE.
  - IDLE, select event only: a <= 1. Stay IDLE.
  - IDLE, both events in the same cycle: the coin is handled as above this cycle, then go to SEL_PEND.
  - SEL_PEND: a <= 1, then return to IDLE unconditionally.
- A new press event cannot occur in SEL_PEND, because DEBOUNCE_CYCLES >= 2 forces release/re-press spacing. The RTL must still not drop it: a coin event in SEL_PEND is registered as pending and serviced in the following IDLE cycle.
- credit is sampled combinationally in the same cycle the coin event is evaluated, not at pulse time.
- credit values above MAX_CREDIT (including 6 and 7) are treated as full and produce coin_reject.
- A select is forwarded regardless of credit; the downstream FSM ignores it at zero credit.
- Invariant: at most one of m, a and coin_reject is high in any cycle.
- Reset mid-operation:
  - A pending select is discarded.
  - A partially counted bounce is discarded.
  - A button still held when reset returns to 1 is seen as a fresh press: one pulse after DEBOUNCE_CYCLES+3 cycles.

Test Plan (DEBOUNCE_CYCLES=4, MAX_CREDIT=5):
- Clean coin press: coin_raw held 1 for 20 cycles with credit=0 -> exactly one m pulse, in cycle 7 after the first sampling edge. a and coin_reject stay 0. Release gives no pulse.
- Bounce rejection: coin_raw toggles 1,0,1,1,0,1,1,1,0 per cycle, then stays 0 -> no output pulse. A subsequent clean 10-cycle press -> one m pulse.
- Simultaneous presses: coin_raw and sel_raw rise on the same edge with credit=2 -> m pulse in cycle N, a pulse in cycle N+1, never overlapping.
- Credit full: credit=5, clean coin press -> coin_reject pulse and no m. Then credit=4 and a second press -> m pulse. credit=7 and a press -> coin_reject.
- Held select: sel_raw held 1 for 100 cycles -> exactly one a pulse.
- Reset: assert reset=0 for one edge while a coin press has cnt=2 and while in SEL_PEND -> all outputs 0 next cycle and the pending a is lost. With coin_raw held 1 through reset, one m pulse 7 cycles after reset returns to 1.
